// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: direction/target check, predictor update
// FIFO, redirect/squash sequencing and branch performance counters.
module branch_resolve_unit #(
  parameter int PC_W       = 32,
  parameter int CTR_W      = 2,
  parameter int HIST_W     = 8,
  parameter int MODE       = 2,
  parameter int UPD_DEPTH  = 2,
  parameter int SQUASH_CYC = 2,
  parameter int PERF_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_valid,
  input  logic              ex_stall,
  input  logic              uncond,
  input  logic              indirect,
  input  logic [1:0]        br_kind,
  input  logic              eq,
  input  logic              ge,
  input  logic [PC_W-1:0]   imm,
  input  logic [PC_W-1:0]   jalr_target,
  input  logic [PC_W-1:0]   pc_ex,
  input  logic              pred_taken,
  input  logic [PC_W-1:0]   pred_target,
  input  logic [CTR_W-1:0]  lctr,
  input  logic [CTR_W-1:0]  gctr,
  input  logic [CTR_W-1:0]  cctr,
  input  logic [HIST_W-1:0] lhist,
  input  logic [HIST_W-1:0] ghist,
  input  logic              upd_ready,
  output logic              upd_valid,
  output logic [PC_W-1:0]   upd_pc,
  output logic              upd_taken,
  output logic [CTR_W-1:0]  upd_lctr,
  output logic [CTR_W-1:0]  upd_gctr,
  output logic [CTR_W-1:0]  upd_cctr,
  output logic [HIST_W-1:0] upd_lhist,
  output logic [HIST_W-1:0] upd_ghist,
  output logic              stall_req,
  output logic              redirect,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              squash,
  output logic [PERF_W-1:0] perf_br,
  output logic [PERF_W-1:0] perf_miss
);

  typedef enum logic [1:0] {IDLE, REDIR, SQUASH} state_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              taken;
    logic [CTR_W-1:0]  lctr;
    logic [CTR_W-1:0]  gctr;
    logic [CTR_W-1:0]  cctr;
    logic [HIST_W-1:0] lhist;
    logic [HIST_W-1:0] ghist;
  } ent_t;

  localparam int AW = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
  localparam int CW = $clog2(UPD_DEPTH + 1);
  localparam int SW = $clog2(SQUASH_CYC + 1);

  state_t            state, state_nxt;
  logic [SW-1:0]     sq_cnt;
  ent_t              mem [UPD_DEPTH];
  ent_t              ent;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              full, push, pop, acc;
  logic              cond, actual, mispredict, lok, gok;
  logic [PC_W-1:0]   actual_pc, redir_q;

  function automatic logic [CTR_W-1:0] sat(
    input logic [CTR_W-1:0] c, input logic up);
    if (up) return (&c) ? c : c + CTR_W'(1);
    else    return (|c) ? c - CTR_W'(1) : c;
  endfunction

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(UPD_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    cond = 1'b0;
    unique case (br_kind)
      2'd0: cond = eq;
      2'd1: cond = !eq;
      2'd2: cond = !ge;
      2'd3: cond = ge;
      default: cond = 1'b0;
    endcase
  end

  assign actual    = uncond | cond;
  assign actual_pc = indirect ? jalr_target
                   : (actual ? pc_ex + imm : pc_ex + PC_W'(4));

  assign upd_valid  = (count != '0);
  assign full       = (count == CW'(UPD_DEPTH));
  assign stall_req  = br_valid & (state == IDLE) & full & !upd_ready;
  assign acc        = br_valid & !ex_stall & !stall_req & (state == IDLE);
  assign push       = acc;
  assign pop        = upd_valid & upd_ready;
  assign mispredict = acc & ((actual != pred_taken) |
                      (actual & pred_taken & (pred_target != actual_pc)));

  assign lok = (lctr[CTR_W-1] == actual);
  assign gok = (gctr[CTR_W-1] == actual);

  always_comb begin
    ent       = '0;
    ent.pc    = pc_ex;
    ent.taken = actual;
    ent.lctr  = (MODE == 1) ? lctr
              : (uncond ? '1 : sat(lctr, actual));
    ent.gctr  = (MODE == 0) ? gctr
              : (uncond ? '1 : sat(gctr, actual));
    ent.lhist = (MODE == 1) ? lhist : {lhist[HIST_W-2:0], actual};
    ent.ghist = (MODE == 0) ? ghist : {ghist[HIST_W-2:0], actual};
    ent.cctr  = cctr;
    // chooser drifts toward whichever predictor alone got it right
    if (MODE == 2) begin
      if (gok && !lok)      ent.cctr = sat(cctr, 1'b1);
      else if (lok && !gok) ent.cctr = sat(cctr, 1'b0);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (mispredict) state_nxt = REDIR;
      REDIR:   state_nxt = SQUASH;
      SQUASH:  if (sq_cnt == SW'(SQUASH_CYC - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sq_cnt    <= '0;
      redir_q   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      perf_br   <= '0;
      perf_miss <= '0;
    end else begin
      state  <= state_nxt;
      sq_cnt <= (state == SQUASH) ? sq_cnt + SW'(1) : '0;
      if (mispredict) redir_q <= actual_pc;
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop)  rd_ptr <= inc(rd_ptr);
      count     <= count + CW'(push) - CW'(pop);
      perf_br   <= perf_br + PERF_W'(acc);
      perf_miss <= perf_miss + PERF_W'(mispredict);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ent;
  end

  assign upd_pc      = mem[rd_ptr].pc;
  assign upd_taken   = mem[rd_ptr].taken;
  assign upd_lctr    = mem[rd_ptr].lctr;
  assign upd_gctr    = mem[rd_ptr].gctr;
  assign upd_cctr    = mem[rd_ptr].cctr;
  assign upd_lhist   = mem[rd_ptr].lhist;
  assign upd_ghist   = mem[rd_ptr].ghist;

  assign redirect    = (state == REDIR);
  assign redirect_pc = (state == REDIR) ? redir_q : '0;
  assign squash      = (state == REDIR) | (state == SQUASH);

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: vector table plus
// FIFO-backpressure, wrong-path and reset sequences.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst, br_valid, ex_stall, uncond, indirect;
  logic [1:0]  br_kind;
  logic        eq, ge, pred_taken, upd_ready;
  logic [31:0] imm, jalr_target, pc_ex, pred_target;
  logic [1:0]  lctr, gctr, cctr;
  logic [7:0]  lhist, ghist;
  logic        upd_valid, upd_taken, stall_req, redirect, squash;
  logic [31:0] upd_pc, redirect_pc, perf_br, perf_miss;
  logic [1:0]  upd_lctr, upd_gctr, upd_cctr;
  logic [7:0]  upd_lhist, upd_ghist;

  branch_resolve_unit dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .ex_stall(ex_stall),
    .uncond(uncond), .indirect(indirect), .br_kind(br_kind),
    .eq(eq), .ge(ge), .imm(imm), .jalr_target(jalr_target),
    .pc_ex(pc_ex), .pred_taken(pred_taken), .pred_target(pred_target),
    .lctr(lctr), .gctr(gctr), .cctr(cctr), .lhist(lhist),
    .ghist(ghist), .upd_ready(upd_ready), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_lctr(upd_lctr),
    .upd_gctr(upd_gctr), .upd_cctr(upd_cctr), .upd_lhist(upd_lhist),
    .upd_ghist(upd_ghist), .stall_req(stall_req), .redirect(redirect),
    .redirect_pc(redirect_pc), .squash(squash), .perf_br(perf_br),
    .perf_miss(perf_miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        unc, ind;
    logic [1:0]  kind;
    logic        eq, ge, pt;
    logic [31:0] pc, imm, jt, ptg;
    logic [1:0]  lc, gc, cc;
    logic [7:0]  lh, gh;
    logic        miss;
    logic [31:0] rpc;
    logic        tk;
    logic [1:0]  elc, egc, ecc;
    logic [7:0]  elh, egh;
  } vec_t;

  vec_t vecs [7];
  int   npass = 0;
  int   ntot  = 0;
  int   nbr   = 0;
  int   nmiss = 0;
  int   sq;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    ntot++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      npass++;
  endtask

  task automatic clr;
    br_valid = 1'b0; ex_stall = 1'b0; uncond = 1'b0;
    indirect = 1'b0; br_kind = 2'd0; eq = 1'b0; ge = 1'b0;
    imm = '0; jalr_target = '0; pc_ex = '0; pred_taken = 1'b0;
    pred_target = '0; lctr = '0; gctr = '0; cctr = '0;
    lhist = '0; ghist = '0;
  endtask

  task automatic apply(input vec_t v);
    uncond = v.unc; indirect = v.ind; br_kind = v.kind;
    eq = v.eq; ge = v.ge; pred_taken = v.pt; pc_ex = v.pc;
    imm = v.imm; jalr_target = v.jt; pred_target = v.ptg;
    lctr = v.lc; gctr = v.gc; cctr = v.cc;
    lhist = v.lh; ghist = v.gh;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0,
                32'h100, 32'h20, 32'h0, 32'h0,
                2'b01, 2'b01, 2'b01, 8'h00, 8'h80,
                1'b1, 32'h120, 1'b1, 2'b10, 2'b10, 2'b01, 8'h01, 8'h01};
    vecs[1] = '{1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0,
                32'h200, 32'h40, 32'h0, 32'h0,
                2'b00, 2'b11, 2'b10, 8'h55, 8'h0F,
                1'b0, 32'h0, 1'b0, 2'b00, 2'b10, 2'b01, 8'hAA, 8'h1E};
    vecs[2] = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1,
                32'h300, 32'h8, 32'h400, 32'h3FC,
                2'b00, 2'b01, 2'b00, 8'hFF, 8'h00,
                1'b1, 32'h400, 1'b1, 2'b11, 2'b11, 2'b00, 8'hFF, 8'h01};
    vecs[3] = '{1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1,
                32'h1000, 32'hFFFFFFF0, 32'h0, 32'h0FF0,
                2'b01, 2'b10, 2'b11, 8'h01, 8'h02,
                1'b0, 32'h0, 1'b1, 2'b10, 2'b11, 2'b11, 8'h03, 8'h05};
    vecs[4] = '{1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1,
                32'hFFFFFFFC, 32'h100, 32'h0, 32'h0FC,
                2'b01, 2'b10, 2'b11, 8'h80, 8'hC3,
                1'b1, 32'h0, 1'b0, 2'b00, 2'b01, 2'b10, 8'h00, 8'h86};
    vecs[5] = '{1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1,
                32'h500, 32'h10, 32'h0, 32'h520,
                2'b11, 2'b11, 2'b01, 8'h7F, 8'h00,
                1'b1, 32'h510, 1'b1, 2'b11, 2'b11, 2'b01, 8'hFF, 8'h01};
    vecs[6] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1,
                32'h40, 32'h100, 32'h0, 32'h140,
                2'b10, 2'b00, 2'b00, 8'h12, 8'h34,
                1'b0, 32'h0, 1'b1, 2'b11, 2'b11, 2'b00, 8'h25, 8'h69};

    clr();
    upd_ready = 1'b1;
    rst = 1'b1;
    step(); step();
    chk("rst_upd_valid", 64'(upd_valid), 64'd0);
    chk("rst_redirect", 64'(redirect), 64'd0);
    chk("rst_redirect_pc", 64'(redirect_pc), 64'd0);
    chk("rst_squash", 64'(squash), 64'd0);
    chk("rst_stall_req", 64'(stall_req), 64'd0);
    chk("rst_perf", 64'({perf_br, perf_miss}), 64'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      apply(vecs[i]);
      br_valid = 1'b1;
      step();
      br_valid = 1'b0;
      chk($sformatf("v%0d_redirect", i), 64'(redirect), 64'(vecs[i].miss));
      chk($sformatf("v%0d_redirect_pc", i), 64'(redirect_pc),
          64'(vecs[i].miss ? vecs[i].rpc : 32'h0));
      chk($sformatf("v%0d_upd_valid", i), 64'(upd_valid), 64'd1);
      chk($sformatf("v%0d_upd_pc", i), 64'(upd_pc), 64'(vecs[i].pc));
      chk($sformatf("v%0d_upd_taken", i), 64'(upd_taken), 64'(vecs[i].tk));
      chk($sformatf("v%0d_ctrs", i), 64'({upd_lctr, upd_gctr, upd_cctr}),
          64'({vecs[i].elc, vecs[i].egc, vecs[i].ecc}));
      chk($sformatf("v%0d_hists", i), 64'({upd_lhist, upd_ghist}),
          64'({vecs[i].elh, vecs[i].egh}));
      sq = 0;
      for (int k = 0; k < 5; k++) begin
        if (squash) sq++;
        step();
      end
      chk($sformatf("v%0d_squash_cycles", i), 64'(sq),
          vecs[i].miss ? 64'd3 : 64'd0);
      nbr++;
      if (vecs[i].miss) nmiss++;
    end
    chk("tbl_perf_br", 64'(perf_br), 64'(nbr));
    chk("tbl_perf_miss", 64'(perf_miss), 64'(nmiss));
    chk("tbl_fifo_drained", 64'(upd_valid), 64'd0);

    // backpressure: two entries fill the FIFO, third must stall
    clr();
    upd_ready = 1'b0;
    br_valid = 1'b1; pc_ex = 32'h10;
    step();
    pc_ex = 32'h20;
    step();
    pc_ex = 32'h30;
    chk("bp_stall_req", 64'(stall_req), 64'd1);
    step();
    chk("bp_no_push_perf", 64'(perf_br), 64'(nbr + 2));
    chk("bp_head_a", 64'(upd_pc), 64'h10);
    upd_ready = 1'b1;
    #1;
    chk("bp_stall_clear", 64'(stall_req), 64'd0);
    step();
    br_valid = 1'b0;
    nbr += 3;
    chk("bp_head_b", 64'(upd_pc), 64'h20);
    chk("bp_perf_br", 64'(perf_br), 64'(nbr));
    step();
    chk("bp_head_c", 64'(upd_pc), 64'h30);
    chk("bp_head_c_valid", 64'(upd_valid), 64'd1);
    step();
    chk("bp_empty", 64'(upd_valid), 64'd0);

    // wrong-path branch arriving in REDIR/SQUASH is dropped
    apply(vecs[0]);
    br_valid = 1'b1;
    step();
    nbr++; nmiss++;
    pc_ex = 32'h700; pred_taken = 1'b1; pred_target = 32'h9999;
    step();
    step();
    chk("wp_squash", 64'(squash), 64'd1);
    chk("wp_no_push", 64'(upd_valid), 64'd0);
    chk("wp_perf_br", 64'(perf_br), 64'(nbr));
    chk("wp_perf_miss", 64'(perf_miss), 64'(nmiss));
    br_valid = 1'b0;
    repeat (3) step();
    chk("wp_idle", 64'(squash), 64'd0);

    // reset in the middle of SQUASH with an entry still queued
    upd_ready = 1'b0;
    apply(vecs[0]);
    br_valid = 1'b1;
    step();
    br_valid = 1'b0;
    step();
    chk("mr_squash_before", 64'(squash), 64'd1);
    chk("mr_queued_before", 64'(upd_valid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_squash", 64'(squash), 64'd0);
    chk("mr_redirect", 64'(redirect), 64'd0);
    chk("mr_fifo_empty", 64'(upd_valid), 64'd0);
    chk("mr_perf", 64'({perf_br, perf_miss}), 64'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
